// File: rtl/cmd_responder.sv
// Device-side command responder: parses 5-byte request frames from the UART receiver,
// runs a register read/write/ping, and returns a 5-byte response. Optional stats: CMD_RESPONDER_STATS_EN.
module cmd_responder #(
  parameter int          ADDR_WIDTH     = 4,
  parameter int          TIMEOUT_CYCLES = 50000,
  parameter logic [7:0]  HDR_REQ        = 8'hAA,
  parameter logic [7:0]  HDR_RSP        = 8'h55
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_rdy,
  output logic                  rx_ack,
  output logic [7:0]            tx_data,
  output logic                  tx_vld,
  input  logic                  tx_rdy,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [7:0]            reg_wdata,
  output logic                  reg_we,
  output logic                  reg_re,
  input  logic [7:0]            reg_rdata
);

  localparam int             CNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]     ADDR_MASK = 8'((1 << ADDR_WIDTH) - 1);

  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_BAD_CHK = 8'h01;
  localparam logic [7:0] ST_BAD_CMD = 8'h02;
  localparam logic [7:0] ST_BAD_ADR = 8'h03;

  typedef enum logic [3:0] {
    HUNT, GET_CMD, GET_ADDR, GET_DATA, GET_CHK, EXEC, RD_WAIT, SEND, SEND_WAIT
  } state_t;

  state_t           state, state_next;
  logic [7:0]       cmd_q, addr_q, data_q, chk_q;
  logic [7:0]       status_q, rdata_q;
  logic [2:0]       tx_idx;
  logic [CNT_W-1:0] to_cnt;
  logic             rx_armed;

  logic             rx_state, in_get, accept, timeout;
  logic             chk_ok, addr_ok;
  logic [7:0]       status_d, rdata_d;
  logic             exec_we, exec_re;

`ifdef CMD_RESPONDER_STATS_EN
  logic [7:0]       good_cnt, err_cnt;
`endif

  assign rx_state = (state == HUNT) || (state == GET_CMD) || (state == GET_ADDR) ||
                    (state == GET_DATA) || (state == GET_CHK);
  assign in_get   = rx_state && (state != HUNT);
  assign accept   = rx_rdy && !rx_ack && rx_armed && rx_state;
  // A byte arriving on the timeout cycle takes precedence over the abort
  assign timeout  = in_get && !accept && (to_cnt == TO_LAST);

  assign chk_ok   = ((cmd_q ^ addr_q ^ data_q) == chk_q);
  assign addr_ok  = ((addr_q & ~ADDR_MASK) == 8'h00);

  always_comb begin
    status_d = ST_OK;
    rdata_d  = 8'h00;
    exec_we  = 1'b0;
    exec_re  = 1'b0;
    if (!chk_ok) begin
      status_d = ST_BAD_CHK;
    end else begin
      case (cmd_q)
        8'h01: begin
          if (addr_ok) begin
            exec_we = 1'b1;
            rdata_d = data_q;
          end else begin
            status_d = ST_BAD_ADR;
          end
        end
        8'h02: begin
          if (addr_ok) exec_re = 1'b1;
          else         status_d = ST_BAD_ADR;
        end
        8'h03: rdata_d = data_q;
`ifdef CMD_RESPONDER_STATS_EN
        8'h04: begin
          if (addr_q == 8'h00)      rdata_d = good_cnt;
          else if (addr_q == 8'h01) rdata_d = err_cnt;
          else                      status_d = ST_BAD_ADR;
        end
`endif
        default: status_d = ST_BAD_CMD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      HUNT:      if (accept && (rx_data == HDR_REQ)) state_next = GET_CMD;
      GET_CMD:   if (accept) state_next = GET_ADDR; else if (timeout) state_next = HUNT;
      GET_ADDR:  if (accept) state_next = GET_DATA; else if (timeout) state_next = HUNT;
      GET_DATA:  if (accept) state_next = GET_CHK;  else if (timeout) state_next = HUNT;
      GET_CHK:   if (accept) state_next = EXEC;     else if (timeout) state_next = HUNT;
      EXEC:      state_next = exec_re ? RD_WAIT : SEND;
      RD_WAIT:   state_next = SEND;
      SEND:      state_next = SEND_WAIT;
      SEND_WAIT: if (tx_rdy) state_next = (tx_idx == 3'd4) ? HUNT : SEND;
      default:   state_next = HUNT;
    endcase
  end

  always_comb begin
    reg_we    = 1'b0;
    reg_re    = 1'b0;
    reg_addr  = '0;
    reg_wdata = 8'h00;
    tx_vld    = 1'b0;
    tx_data   = 8'h00;
    if (state == EXEC) begin
      reg_we    = exec_we;
      reg_re    = exec_re;
      reg_addr  = addr_q[ADDR_WIDTH-1:0];
      reg_wdata = data_q;
    end
    if ((state == SEND) || (state == SEND_WAIT)) begin
      tx_vld = (state == SEND);
      case (tx_idx)
        3'd0:    tx_data = HDR_RSP;
        3'd1:    tx_data = cmd_q;
        3'd2:    tx_data = status_q;
        3'd3:    tx_data = rdata_q;
        default: tx_data = cmd_q ^ status_q ^ rdata_q;
      endcase
    end
  end

  // Receive handshake and frame capture; re-arm only after the receiver drops rx_rdy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ack   <= 1'b0;
      rx_armed <= 1'b0;
      cmd_q    <= 8'h00;
      addr_q   <= 8'h00;
      data_q   <= 8'h00;
      chk_q    <= 8'h00;
      to_cnt   <= '0;
    end else begin
      rx_ack <= accept;
      if (accept)       rx_armed <= 1'b0;
      else if (!rx_rdy) rx_armed <= 1'b1;

      if (accept) begin
        case (state)
          GET_CMD:  cmd_q  <= rx_data;
          GET_ADDR: addr_q <= rx_data;
          GET_DATA: data_q <= rx_data;
          GET_CHK:  chk_q  <= rx_data;
          default:  ;
        endcase
      end

      if (!in_get || accept || timeout) to_cnt <= '0;
      else                              to_cnt <= to_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= 8'h00;
      rdata_q  <= 8'h00;
      tx_idx   <= 3'd0;
    end else begin
      case (state)
        EXEC: begin
          status_q <= status_d;
          rdata_q  <= rdata_d;
          tx_idx   <= 3'd0;
        end
        RD_WAIT:   rdata_q <= reg_rdata;
        SEND_WAIT: if (tx_rdy) tx_idx <= (tx_idx == 3'd4) ? 3'd0 : tx_idx + 3'd1;
        default:   ;
      endcase
    end
  end

`ifdef CMD_RESPONDER_STATS_EN
  // Counters are sampled for a stats read before that response's own increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      good_cnt <= 8'h00;
      err_cnt  <= 8'h00;
    end else if (state == EXEC) begin
      if (status_d == ST_OK) begin
        if (good_cnt != 8'hFF) good_cnt <= good_cnt + 8'd1;
      end else begin
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
    end else if (timeout) begin
      if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cmd_responder.sv
// Directed bench for cmd_responder: request frames with hand-computed response bytes,
// timeout, backpressure and mid-response reset.
module tb_cmd_responder;

  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       rx_ack;
  logic [7:0] tx_data;
  logic       tx_vld;
  logic       tx_rdy = 1'b0;
  logic [3:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata = 8'h00;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         last_ack_cyc = 0;
  int         first_lat = -1;
  int         we_cnt = 0, re_cnt = 0, bp_acks = 0;
  logic [3:0] we_addr = '0, re_addr = '0;
  logic [7:0] we_data = '0;
  logic       bp_window = 1'b0;
  logic [7:0] tx_q[$];
  logic [2:0] tx_dly = 3'd0;

  cmd_responder #(
    .ADDR_WIDTH(4), .TIMEOUT_CYCLES(TO), .HDR_REQ(8'hAA), .HDR_RSP(8'h55)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_rdy(rx_rdy), .rx_ack(rx_ack),
    .tx_data(tx_data), .tx_vld(tx_vld), .tx_rdy(tx_rdy),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register bus returns C3 only in the cycle after a read strobe
  always @(posedge clk) reg_rdata <= reg_re ? 8'hC3 : 8'h00;

  // Transmitter reports completion three cycles after each start pulse
  always @(posedge clk) begin
    tx_rdy <= 1'b0;
    if (tx_vld) tx_dly <= 3'd3;
    else if (tx_dly != 3'd0) begin
      tx_dly <= tx_dly - 3'd1;
      if (tx_dly == 3'd1) tx_rdy <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rx_ack) begin
      last_ack_cyc = cyc;
      if (bp_window) bp_acks++;
    end
    if (tx_vld) begin
      if (tx_q.size() == 0) first_lat = cyc - last_ack_cyc;
      tx_q.push_back(tx_data);
    end
    if (reg_we) begin we_cnt++; we_addr = reg_addr; we_data = reg_wdata; end
    if (reg_re) begin re_cnt++; re_addr = reg_addr; end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    logic seen;
    seen = 1'b0;
    rx_data = b;
    rx_rdy  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rx_ack) begin seen = 1'b1; break; end
    end
    checkOutput("rx_ack", {31'd0, seen}, 32'd1);
    rx_rdy = 1'b0;
    @(negedge clk);
  endtask

  task automatic sendFrame(input logic [39:0] f);
    tx_q.delete();
    first_lat = -1;
    for (int k = 4; k >= 0; k--) applyStimulus(f[k*8 +: 8]);
  endtask

  task automatic expectResponse(input string tag, input logic [39:0] e);
    logic [31:0] got;
    for (int i = 0; i < 200 && tx_q.size() < 5; i++) @(negedge clk);
    checkOutput({tag, "_len"}, tx_q.size(), 32'd5);
    repeat (8) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      got = (k < tx_q.size()) ? {24'd0, tx_q[k]} : 32'hFFFF;
      checkOutput($sformatf("%s_b%0d", tag, k), got, {24'd0, e[(4-k)*8 +: 8]});
    end
  endtask

  initial begin
    rst_n = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00;
    repeat (2) @(negedge clk);
    checkOutput("rst_tx_vld", {31'd0, tx_vld}, 32'd0);
    checkOutput("rst_tx_data", {24'd0, tx_data}, 32'd0);
    checkOutput("rst_rx_ack", {31'd0, rx_ack}, 32'd0);
    checkOutput("rst_we_re", {30'd0, reg_we, reg_re}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    sendFrame(40'hAA_01_03_5A_58);
    expectResponse("wr", 40'h55_01_00_5A_5B);
    checkOutput("wr_we_cnt", we_cnt, 32'd1);
    checkOutput("wr_addr", {28'd0, we_addr}, 32'd3);
    checkOutput("wr_data", {24'd0, we_data}, 32'h5A);
    checkOutput("wr_lat", first_lat, 32'd1);

    sendFrame(40'hAA_02_03_00_01);
    expectResponse("rd", 40'h55_02_00_C3_C1);
    checkOutput("rd_re_cnt", re_cnt, 32'd1);
    checkOutput("rd_addr", {28'd0, re_addr}, 32'd3);
    checkOutput("rd_lat", first_lat, 32'd2);

    sendFrame(40'hAA_01_03_5A_00);
    expectResponse("chk", 40'h55_01_01_00_00);
    checkOutput("chk_no_we", we_cnt, 32'd1);

    sendFrame(40'hAA_07_00_00_07);
    expectResponse("cmd", 40'h55_07_02_00_05);
    sendFrame(40'hAA_02_10_00_12);
    expectResponse("adr", 40'h55_02_03_00_01);
    checkOutput("adr_no_re", re_cnt, 32'd1);

    // Junk is consumed, then a truncated frame is abandoned by the timeout
    tx_q.delete();
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'hAA);
    applyStimulus(8'h01);
    repeat (TO + 5) @(negedge clk);
    checkOutput("to_no_tx", tx_q.size(), 32'd0);
    sendFrame(40'hAA_03_00_7E_7D);
    expectResponse("ping", 40'h55_03_00_7E_7D);
    checkOutput("ping_no_we", we_cnt, 32'd1);

    // Hold a byte pending during the response, then reset during byte 2
    sendFrame(40'hAA_03_00_11_12);
    rx_data = 8'hAA; rx_rdy = 1'b1; bp_window = 1'b1;
    for (int i = 0; i < 200 && tx_q.size() < 3; i++) @(negedge clk);
    checkOutput("bp_bytes", tx_q.size(), 32'd3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("bp_acks", bp_acks, 32'd0);
    checkOutput("mrst_tx_vld", {31'd0, tx_vld}, 32'd0);
    checkOutput("mrst_tx_data", {24'd0, tx_data}, 32'd0);
    rx_rdy = 1'b0; bp_window = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    tx_q.delete();
    repeat (10) @(negedge clk);
    checkOutput("mrst_no_resume", tx_q.size(), 32'd0);

    sendFrame(40'hAA_03_00_3C_3F);
    expectResponse("ping2", 40'h55_03_00_3C_3F);

    sendFrame(40'hAA_04_00_00_04);
`ifdef CMD_RESPONDER_STATS_EN
    expectResponse("stat_good", 40'h55_04_00_01_05);
    sendFrame(40'hAA_04_01_00_05);
    expectResponse("stat_err", 40'h55_04_00_00_04);
    sendFrame(40'hAA_04_02_00_06);
    expectResponse("stat_adr", 40'h55_04_03_00_07);
`else
    expectResponse("stat_off", 40'h55_04_02_00_06);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
